// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory path: default widths,
// controller states and the value the memory is cleared to.
package cpu_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 8;

    typedef enum logic {
        IMEM_INIT = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_t;

    localparam logic [7:0] NOP_INSTR = 8'h00;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM backing the instruction memory.
// Read data is registered and reflects the addressed word before any same-edge write.
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: clears the RAM after reset, then arbitrates the
// single access slot between fetch reads and loader writes with a starvation guard.
module imem_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              init_done
);

    localparam int                SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] CLR_LAST   = '1;

    imem_state_t       state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              init_done_reg;
    logic              fetch_valid_reg;
    logic [DATA_W-1:0] last_instr_reg;
    logic [SW-1:0]     starve_cnt_reg;

    logic              starve_hit;
    logic              ld_hs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Grants are held off until init_done, one cycle after the last clear write.
    always_comb begin
        starve_hit = (starve_cnt_reg == STARVE_LIM);
        fetch_gnt  = init_done_reg & fetch_req & ~(ld_valid & starve_hit);
        ld_ready   = init_done_reg & (~fetch_req | starve_hit);
        ld_hs      = ld_valid & ld_ready;
        ram_we     = 1'b0;
        ram_addr   = fetch_addr;
        ram_wdata  = ld_data;
        if (state_reg == IMEM_INIT) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_reg;
            ram_wdata = DATA_W'(NOP_INSTR);
        end else if (ld_hs) begin
            ram_we   = 1'b1;
            ram_addr = ld_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IMEM_INIT;
            clr_cnt_reg     <= '0;
            init_done_reg   <= 1'b0;
            fetch_valid_reg <= 1'b0;
            last_instr_reg  <= '0;
            starve_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IMEM_INIT: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == CLR_LAST) begin
                        state_reg <= IMEM_RUN;
                    end
                end
                IMEM_RUN: begin
                    init_done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IMEM_INIT;
                end
            endcase

            fetch_valid_reg <= fetch_gnt;
            if (fetch_valid_reg) begin
                last_instr_reg <= ram_rdata;
            end

            // A stalled loader implies !starve_hit, so this never overshoots the limit.
            if (!ld_valid || ld_hs) begin
                starve_cnt_reg <= '0;
            end else if (init_done_reg && !starve_hit) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

    assign fetch_valid = fetch_valid_reg;
    assign fetch_instr = fetch_valid_reg ? ram_rdata : last_instr_reg;
    assign init_done   = init_done_reg;

    imem_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized and directed bench for imem_ctrl against a memory-array and
// stall-count reference model.
module tb_imem_ctrl;

    localparam int STARVE_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_gnt;
    logic       fetch_valid;
    logic [7:0] fetch_instr;
    logic       ld_valid;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       init_done;

    logic [7:0] model [256];
    int         stall;
    logic [7:0] last;
    logic       m_gnt;
    logic       m_hs;
    logic       obs_rdy;
    int         errs;
    int         total;

    imem_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle of requests and checks it end to end.
    task automatic do_cycle(input logic fr, input logic [7:0] fa, input logic lv,
                            input logic [7:0] la, input logic [7:0] ldd);
        logic       exp_gnt;
        logic       exp_rdy;
        logic [7:0] exp_data;
        fetch_req  = fr;
        fetch_addr = fa;
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ldd;
        #4;
        exp_rdy  = !fr || (stall == STARVE_MAX);
        exp_gnt  = fr && !(lv && stall == STARVE_MAX);
        exp_data = model[fa];
        check("fetch_gnt", fetch_gnt, exp_gnt);
        check("ld_ready", ld_ready, exp_rdy);
        obs_rdy = ld_ready;
        m_gnt   = exp_gnt;
        m_hs    = lv && exp_rdy;
        @(posedge clk);
        #1;
        if (m_hs) begin
            model[la] = ldd;
            $display("t=%0t load  a=%02h d=%02h", $time, la, ldd);
        end
        if (!lv || m_hs) stall = 0;
        else if (stall < STARVE_MAX) stall++;
        check("fetch_valid", fetch_valid, exp_gnt);
        if (exp_gnt) begin
            last = exp_data;
            $display("t=%0t fetch a=%02h d=%02h", $time, fa, fetch_instr);
        end
        check("fetch_instr", fetch_instr, last);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        check("rst_valid", fetch_valid, 0);
        check("rst_instr", fetch_instr, 0);
        check("rst_done", init_done, 0);
        check("rst_gnt", fetch_gnt, 0);
        check("rst_rdy", ld_ready, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Releases reset and counts edges until init_done; abort_at>0 re-asserts reset at that edge.
    task automatic run_init(input int abort_at);
        int k;
        k         = 0;
        ld_valid  = 1'b0;
        fetch_req = 1'b0;
        rst_n     = 1'b1;
        while (k < 400 && !init_done) begin
            fetch_req = 1'($urandom_range(0, 1));
            #1;
            check("init_gnt", fetch_gnt, 0);
            check("init_rdy", ld_ready, 0);
            @(posedge clk);
            k++;
            #1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_done", init_done, 0);
                return;
            end
        end
        fetch_req = 1'b0;
        check("init_edges", k, 257);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        stall = 0;
        last  = 8'h00;
    endtask

    initial begin
        logic       pend;
        logic       lpend;
        logic [7:0] pa;
        logic [7:0] la_r;
        logic [7:0] ld_r;
        logic [7:0] wa [4];
        logic [7:0] wd [4];
        errs       = 0;
        total      = 0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 8'h00;
        ld_valid   = 1'b0;
        ld_addr    = 8'h00;
        ld_data    = 8'h00;
        stall      = 0;
        last       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();
        run_init(0);

        for (int a = 0; a < 256; a++) do_cycle(1'b1, 8'(a), 1'b0, 8'h00, 8'h00);
        do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        wa = '{8'h00, 8'h01, 8'h02, 8'h05};
        wd = '{8'h40, 8'h51, 8'h29, 8'hE7};
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 8'h00, 1'b1, wa[i], wd[i]);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, wa[i], 1'b0, 8'h00, 8'h00);
            check("load_readback", fetch_instr, wd[i]);
            do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        end

        for (int a = 0; a < 8; a++) do_cycle(1'b1, 8'(a), 1'b0, 8'h00, 8'h00);
        do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 8'(i), 1'b1, 8'h07, 8'hC7);
            check("force_rdy", obs_rdy, (i == 3));
        end
        do_cycle(1'b1, 8'h07, 1'b0, 8'h00, 8'h00);
        check("force_data", fetch_instr, 8'hC7);

        do_cycle(1'b0, 8'h00, 1'b1, 8'h06, 8'hC6);
        do_cycle(1'b1, 8'h06, 1'b0, 8'h00, 8'h00);
        check("raw_data", fetch_instr, 8'hC6);

        pend  = 1'b0;
        lpend = 1'b0;
        pa    = 8'h00;
        la_r  = 8'h00;
        ld_r  = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if (!pend) begin
                pend = ($urandom % 3) != 0;
                pa   = 8'($urandom);
            end
            if (!lpend) begin
                lpend = ($urandom % 2) != 0;
                la_r  = 8'($urandom);
                ld_r  = 8'($urandom);
            end
            do_cycle(pend, pa, lpend, la_r, ld_r);
            if (m_gnt) pend = 1'b0;
            if (m_hs) lpend = 1'b0;
        end

        for (int a = 0; a < 4; a++) do_cycle(1'b1, 8'(a), 1'b0, 8'h00, 8'h00);
        reset_pulse();
        run_init(0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1, 8'(i * 16), 8'(8'hA0 + i));
        reset_pulse();
        run_init(100);
        reset_pulse();
        run_init(0);
        for (int a = 0; a < 256; a++) do_cycle(1'b1, 8'(a), 1'b0, 8'h00, 8'h00);
        do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
